// File: rtl/fxp_seq_pkg.sv
// Shared types and width helpers for the fixed-point extract sequencer.
package fxp_seq_pkg;

  localparam int DEF_W       = 16;
  localparam int DEF_N_VEC   = 8;
  localparam int DEF_TIMEOUT = 15;

  // Never returns 0, so a single-entry table still gets a 1-bit index.
  function automatic int clog2_min1(input int value);
    return (value <= 2) ? 1 : $clog2(value);
  endfunction

  localparam int IDX_W = clog2_min1(DEF_N_VEC);
  localparam int BIT_W = clog2_min1(DEF_W);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    ISSUE,
    WAIT,
    CHECK,
    DONE
  } state_t;

endpackage

// File: rtl/fxp_seq_timeout.sv
// Response watchdog: loaded on request acceptance, counts down while waiting.
module fxp_seq_timeout
  import fxp_seq_pkg::*;
#(
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic clock,
  input  logic reset,
  input  logic load,
  input  logic en,
  output logic expired
);

  localparam int CNT_W = clog2_min1(TIMEOUT + 1);

  logic [CNT_W-1:0] count;

  // Loading TIMEOUT-1 makes the last allowed wait cycle the one where count hits 0.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= CNT_W'(TIMEOUT - 1);
    end else if (en && count != '0) begin
      count <= count - CNT_W'(1);
    end
  end

  assign expired = en && (count == '0);

endmodule

// File: rtl/fixed_point_extract_sequencer.sv
// Walks an external vector table, issues each vector to the extract datapath,
// and checks every response, keeping a failure count and first failing index.
module fixed_point_extract_sequencer
  import fxp_seq_pkg::*;
#(
  parameter int W       = DEF_W,
  parameter int N_VEC   = DEF_N_VEC,
  parameter int TIMEOUT = DEF_TIMEOUT,
  localparam int A_W    = clog2_min1(N_VEC),
  localparam int B_W    = clog2_min1(W),
  localparam int C_W    = clog2_min1(N_VEC + 1)
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           start,
  output logic [A_W-1:0] vec_addr,
  input  logic [W-1:0]   vec_lit,
  input  logic [B_W-1:0] vec_hi,
  input  logic [B_W-1:0] vec_lo,
  input  logic [W-1:0]   vec_exp,
  output logic           req_valid,
  input  logic           req_ready,
  output logic [W-1:0]   req_lit,
  output logic [B_W-1:0] req_hi,
  output logic [B_W-1:0] req_lo,
  input  logic           rsp_valid,
  input  logic [W-1:0]   rsp_bits,
  output logic           busy,
  output logic           done,
  output logic           pass,
  output logic [C_W-1:0] fail_count,
  output logic [A_W-1:0] fail_idx
);

  state_t         state, state_next;
  logic [A_W-1:0] idx;
  logic [W-1:0]   exp_q;
  logic [W-1:0]   rsp_q;
  logic           timed_out;
  logic           expired;
  logic           last;
  logic           mismatch;

  assign last     = (idx == A_W'(N_VEC - 1));
  assign mismatch = timed_out || (rsp_q != exp_q);

  fxp_seq_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clock   (clock),
    .reset   (reset),
    .load    (state == ISSUE && req_ready),
    .en      (state == WAIT),
    .expired (expired)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE, DONE: if (start) state_next = FETCH;
      FETCH:      state_next = ISSUE;
      ISSUE:      if (req_ready) state_next = WAIT;
      WAIT:       if (rsp_valid || expired) state_next = CHECK;
      CHECK:      state_next = last ? DONE : FETCH;
      default:    state_next = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state != IDLE) && (state != DONE);
    req_valid = (state == ISSUE);
  end

  // vec_addr runs one vector ahead of idx so a registered-read table has
  // its data ready by the time FETCH samples it; it wraps to 0 after the last.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      idx        <= '0;
      vec_addr   <= '0;
      req_lit    <= '0;
      req_hi     <= '0;
      req_lo     <= '0;
      exp_q      <= '0;
      rsp_q      <= '0;
      timed_out  <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      fail_count <= '0;
      fail_idx   <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            idx        <= '0;
            done       <= 1'b0;
            pass       <= 1'b0;
            fail_count <= '0;
            fail_idx   <= '0;
          end
        end
        FETCH: begin
          req_lit   <= vec_lit;
          req_hi    <= vec_hi;
          req_lo    <= vec_lo;
          exp_q     <= vec_exp;
          timed_out <= 1'b0;
          vec_addr  <= last ? '0 : idx + A_W'(1);
        end
        WAIT: begin
          if (rsp_valid)    rsp_q     <= rsp_bits;
          else if (expired) timed_out <= 1'b1;
        end
        CHECK: begin
          if (mismatch) begin
            if (fail_count != C_W'(N_VEC)) fail_count <= fail_count + C_W'(1);
            if (fail_count == '0)          fail_idx   <= idx;
          end
          if (last) begin
            done <= 1'b1;
            pass <= !mismatch && (fail_count == '0);
          end else begin
            idx <= idx + A_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
